// File: rtl/riscv_wb_pkg.sv
// rtl/riscv_wb_pkg.sv - shared sizes, writeback entry type and hazard helper
package riscv_wb_pkg;

    localparam int TAG_DEPTH = 4;
    localparam int BUF_DEPTH = 2;
    localparam int XLEN      = 32;
    localparam int REG_AW    = 5;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

    localparam int ENTRY_W = $bits(wb_entry_t);
    localparam int TAG_CW  = $clog2(TAG_DEPTH + 1);
    localparam int BUF_CW  = $clog2(BUF_DEPTH + 1);

    // x0 is never a real dependency, so it can never hit.
    function automatic logic reg_hit(input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] rs1,
                                     input logic [REG_AW-1:0] rs2,
                                     input logic [REG_AW-1:0] id_rd);
        return (rd != '0) && ((rd == rs1) || (rd == rs2) || (rd == id_rd));
    endfunction

endpackage

// File: rtl/writeback_arbiter_fifo.sv
// rtl/writeback_arbiter_fifo.sv - wb_fifo: small in-order FIFO exposing every slot
module wb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_push,
    input  logic                        i_pop,
    input  logic [WIDTH-1:0]            i_data,
    output logic [WIDTH-1:0]            o_head,
    output logic                        o_full,
    output logic                        o_empty,
    output logic [CW-1:0]               o_count,
    output logic [DEPTH-1:0][WIDTH-1:0] o_entries,
    output logic [DEPTH-1:0]            o_valid
);

    logic [DEPTH-1:0][WIDTH-1:0] r_mem;
    logic [PW-1:0]               r_rd_ptr;
    logic [PW-1:0]               r_wr_ptr;
    logic [CW-1:0]               r_count;
    logic [DEPTH-1:0]            r_valid;
    logic [DEPTH-1:0]            w_valid_nxt;
    logic                        w_push;
    logic                        w_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign o_entries = r_mem;
    assign o_valid   = r_valid;

    // A pop frees the slot the push lands in when full.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_comb begin
        w_valid_nxt = r_valid;
        if (w_pop)
            w_valid_nxt[r_rd_ptr] = 1'b0;
        if (w_push)
            w_valid_nxt[r_wr_ptr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
        end else begin
            if (w_pop)
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_push)
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            r_valid <= w_valid_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - merges ALU results and in-order load returns onto one RF write port
module writeback_arbiter
    import riscv_wb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_alu_valid,
    input  logic [REG_AW-1:0] i_alu_rd,
    input  logic [XLEN-1:0]   i_alu_data,
    input  logic              i_ld_issue,
    input  logic [REG_AW-1:0] i_ld_issue_rd,
    output logic              o_issue_ready,
    input  logic              i_ld_resp_valid,
    input  logic [XLEN-1:0]   i_ld_resp_data,
    output logic              o_ld_resp_ready,
    input  logic [REG_AW-1:0] i_id_rs1,
    input  logic [REG_AW-1:0] i_id_rs2,
    input  logic [REG_AW-1:0] i_id_rd,
    output logic              o_stall,
    output logic              o_rf_we,
    output logic [REG_AW-1:0] o_rf_addr,
    output logic [XLEN-1:0]   o_rf_wd,
    output logic              o_ld_err
);

    logic                                w_tag_full, w_tag_empty;
    logic [REG_AW-1:0]                   w_tag_head;
    logic [TAG_CW-1:0]                   w_tag_count;
    logic [TAG_DEPTH-1:0][REG_AW-1:0]    w_tag_ent;
    logic [TAG_DEPTH-1:0]                w_tag_vld;
    logic                                w_buf_full, w_buf_empty;
    wb_entry_t                           w_buf_head;
    logic [BUF_CW-1:0]                   w_buf_count;
    logic [BUF_DEPTH-1:0][ENTRY_W-1:0]   w_buf_ent;
    logic [BUF_DEPTH-1:0]                w_buf_vld;
    logic                                w_resp_acc, w_issue_push;
    logic                                w_buf_push, w_buf_pop, w_bypass;
    logic                                w_cand_vld, w_write, w_stall;
    wb_entry_t                           w_resp_entry, w_cand;
    logic                                w_unused_counts;
    logic                                r_rf_we;
    logic [REG_AW-1:0]                   r_rf_addr;
    logic [XLEN-1:0]                     r_rf_wd;
    logic                                r_ld_err;

    assign w_unused_counts = ^{w_tag_count, w_buf_count};

    // A full buffer can still take a response when its head drains this cycle.
    assign o_ld_resp_ready = !w_buf_full || !i_alu_valid;
    assign w_resp_acc      = i_ld_resp_valid && o_ld_resp_ready && !w_tag_empty;
    assign o_issue_ready   = !w_tag_full || w_resp_acc;
    assign w_issue_push    = i_ld_issue && o_issue_ready;

    assign w_buf_pop    = !i_alu_valid && !w_buf_empty;
    assign w_bypass     = w_resp_acc && !i_alu_valid && w_buf_empty;
    assign w_buf_push   = w_resp_acc && !w_bypass;
    assign w_resp_entry = '{rd: w_tag_head, data: i_ld_resp_data};

    wb_fifo #(.WIDTH(REG_AW), .DEPTH(TAG_DEPTH)) u_tag_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (w_issue_push),
        .i_pop     (w_resp_acc),
        .i_data    (i_ld_issue_rd),
        .o_head    (w_tag_head),
        .o_full    (w_tag_full),
        .o_empty   (w_tag_empty),
        .o_count   (w_tag_count),
        .o_entries (w_tag_ent),
        .o_valid   (w_tag_vld)
    );

    wb_fifo #(.WIDTH(ENTRY_W), .DEPTH(BUF_DEPTH)) u_data_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (w_buf_push),
        .i_pop     (w_buf_pop),
        .i_data    (w_resp_entry),
        .o_head    (w_buf_head),
        .o_full    (w_buf_full),
        .o_empty   (w_buf_empty),
        .o_count   (w_buf_count),
        .o_entries (w_buf_ent),
        .o_valid   (w_buf_vld)
    );

    always_comb begin
        w_cand_vld = 1'b1;
        w_cand     = w_resp_entry;
        if (i_alu_valid)
            w_cand = '{rd: i_alu_rd, data: i_alu_data};
        else if (!w_buf_empty)
            w_cand = w_buf_head;
        else if (!w_bypass)
            w_cand_vld = 1'b0;
    end

    assign w_write = w_cand_vld && (w_cand.rd != '0);

    // The rf_* register itself never stalls: the RF absorbs it on the negedge.
    always_comb begin
        w_stall = w_buf_full;
        for (int i = 0; i < TAG_DEPTH; i++)
            if (w_tag_vld[i] && reg_hit(w_tag_ent[i], i_id_rs1, i_id_rs2, i_id_rd))
                w_stall = 1'b1;
        for (int j = 0; j < BUF_DEPTH; j++)
            if (w_buf_vld[j] && reg_hit(w_buf_ent[j][ENTRY_W-1 -: REG_AW], i_id_rs1, i_id_rs2, i_id_rd))
                w_stall = 1'b1;
    end

    assign o_stall = w_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rf_we   <= 1'b0;
            r_rf_addr <= '0;
            r_rf_wd   <= '0;
            r_ld_err  <= 1'b0;
        end else begin
            r_rf_we <= w_write;
            if (w_write) begin
                r_rf_addr <= w_cand.rd;
                r_rf_wd   <= w_cand.data;
            end
            if ((i_ld_resp_valid && w_tag_empty) || (i_ld_issue && !o_issue_ready))
                r_ld_err <= 1'b1;
        end
    end

    assign o_rf_we   = r_rf_we;
    assign o_rf_addr = r_rf_addr;
    assign o_rf_wd   = r_rf_wd;
    assign o_ld_err  = r_ld_err;

endmodule
